// File: rtl/room_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : room_cmd_rx
// Brief    : 8N1 UART receiver with ASCII digit / lock command decode.
// Revision : 1.0
// ============================================================================
module room_cmd_rx #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BAUD          = 115200,
    parameter int UNLOCK_CYCLES = 150_000_000
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_valid,
    output logic       frame_err,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       unlock,
    output logic [7:0] LED
);

    localparam int c_DIV = CLK_HZ / BAUD;
    localparam int c_CW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_UW  = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;

    localparam logic [c_CW-1:0] c_HALF  = c_CW'(c_DIV / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(c_DIV - 1);
    localparam logic [c_UW-1:0] c_ULOAD = c_UW'(UNLOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_rx_meta, r_rx_s;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            w_valid_nxt, w_ferr_nxt;
    logic [7:0]      r_data;
    logic            r_valid, r_ferr;
    logic [3:0]      r_digit;
    logic            r_digit_valid;
    logic            r_unlock;
    logic [c_UW-1:0] r_ucnt;
    logic            w_is_digit;

    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RxD;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            if (w_valid_nxt) begin
                r_data <= r_shift;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = c_HALF;
                end
            end
            S_START: begin
                if (r_cnt == '0) begin
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = c_FULL;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    // LSB arrives first, so shifting in at the MSB leaves it in bit 0
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt   = c_FULL;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == '0) begin
                    if (r_rx_s) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_HI;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_is_digit = (r_data >= 8'h30) && (r_data <= 8'h39);

    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            r_digit       <= '0;
            r_digit_valid <= 1'b0;
            r_unlock      <= 1'b0;
            r_ucnt        <= '0;
        end else begin
            r_digit_valid <= 1'b0;
            // For '0'..'9' the byte minus 0x30 is exactly its low nibble
            if (r_valid && w_is_digit) begin
                r_digit       <= r_data[3:0];
                r_digit_valid <= 1'b1;
            end
            if (r_valid && (r_data == 8'h55)) begin
                r_unlock <= 1'b1;
                r_ucnt   <= c_ULOAD;
            end else if (r_valid && (r_data == 8'h4C)) begin
                r_unlock <= 1'b0;
                r_ucnt   <= '0;
            end else if (r_unlock) begin
                if (r_ucnt == '0) begin
                    r_unlock <= 1'b0;
                end else begin
                    r_ucnt <= r_ucnt - 1'b1;
                end
            end
        end
    end

    assign RxD_data    = r_data;
    assign LED         = r_data;
    assign RxD_valid   = r_valid;
    assign frame_err   = r_ferr;
    assign digit       = r_digit;
    assign digit_valid = r_digit_valid;
    assign unlock      = r_unlock;

endmodule
`default_nettype wire

// File: tb/tb_room_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_room_cmd_rx
// Brief    : Directed plus randomized frame bench for room_cmd_rx.
// Revision : 1.0
// ============================================================================
module tb_room_cmd_rx;

    localparam int CLK_HZ        = 1_000_000;
    localparam int BAUD          = 100_000;
    localparam int UNLOCK_CYCLES = 100;
    localparam int DIV           = CLK_HZ / BAUD;
    // start bit on pin -> RxD_valid: 2 sync cycles, stop sample DIV/2+9*DIV later, strobe the cycle after
    localparam int LAT           = 2 + DIV / 2 + 9 * DIV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_valid;
    logic       frame_err;
    logic [3:0] digit;
    logic       digit_valid;
    logic       unlock;
    logic [7:0] LED;

    always #5 clk = ~clk;

    room_cmd_rx #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .UNLOCK_CYCLES(UNLOCK_CYCLES)
    ) dut (
        .FPGA_CLK1_50(clk),
        .reset       (reset),
        .RxD         (RxD),
        .RxD_data    (RxD_data),
        .RxD_valid   (RxD_valid),
        .frame_err   (frame_err),
        .digit       (digit),
        .digit_valid (digit_valid),
        .unlock      (unlock),
        .LED         (LED)
    );

    typedef struct {
        int         cyc;
        bit         ok;
        logic [7:0] b;
    } ev_t;

    ev_t        ev_q[$];
    int         vcyc_q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_data = '0;
    logic [3:0] m_digit = '0;
    int         m_until = -1;
    bit         m_pend = 1'b0;
    logic [7:0] m_pend_b = '0;
    bit         e_valid, e_ferr, e_dv;
    int         n_valid = 0, n_ferr = 0, n_dv = 0;
    int         run = 0, last_run = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        ev_q.delete();
        m_data  = '0;
        m_digit = '0;
        m_until = -1;
        m_pend  = 1'b0;
        e_valid = 1'b0;
        e_ferr  = 1'b0;
        e_dv    = 1'b0;
    endtask

    // Expected behaviour for the current cycle: decode effects of last cycle's byte, then this cycle's frame end.
    task automatic model_advance();
        ev_t e;
        e_valid = 1'b0;
        e_ferr  = 1'b0;
        e_dv    = 1'b0;
        if (m_pend) begin
            if (m_pend_b >= "0" && m_pend_b <= "9") begin
                m_digit = 4'(m_pend_b - 8'h30);
                e_dv    = 1'b1;
            end else if (m_pend_b == "U") begin
                m_until = cyc + UNLOCK_CYCLES - 1;
            end else if (m_pend_b == "L") begin
                m_until = cyc - 1;
            end
            m_pend = 1'b0;
        end
        if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
            e = ev_q.pop_front();
            if (e.ok) begin
                e_valid  = 1'b1;
                m_data   = e.b;
                m_pend   = 1'b1;
                m_pend_b = e.b;
            end else begin
                e_ferr = 1'b1;
            end
        end
    endtask

    task automatic check_cycle();
        logic [23:0] obs, expv;
        obs  = {RxD_data, RxD_valid, frame_err, digit, digit_valid, unlock, LED};
        expv = {m_data, e_valid, e_ferr, m_digit, e_dv, (cyc <= m_until), m_data};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL cycle %0d: observed %h expected %h", cyc, obs, expv);
        end
        if (RxD_valid === 1'b1) begin
            n_valid++;
            vcyc_q.push_back(cyc);
        end
        if (frame_err === 1'b1) n_ferr++;
        if (digit_valid === 1'b1) n_dv++;
        if (unlock === 1'b1) begin
            run++;
        end else if (run > 0) begin
            last_run = run;
            run      = 0;
        end
    endtask

    task automatic step(input logic rx, input logic rst_in);
        @(posedge clk);
        #1;
        RxD   = rx;
        reset = rst_in;
        cyc++;
        if (rst_in) model_reset();
        else model_advance();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        e.cyc = cyc + 1 + LAT;
        e.ok  = stop_ok;
        e.b   = b;
        ev_q.push_back(e);
        repeat (DIV) step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) repeat (DIV) step(b[i], 1'b0);
        repeat (DIV) step(stop_ok, 1'b0);
    endtask

    initial begin
        int nv, nf, nd, k;
        logic [7:0] rb;
        int pick, gap;
        bit ok;

        reset = 1'b1;
        RxD   = 1'b1;
        repeat (3) step(1'b1, 1'b1);
        chk("reset_outputs", int'({RxD_data, RxD_valid, frame_err, digit, digit_valid, unlock, LED}), 0);
        idle(5);

        // Single digit
        nv = n_valid; nf = n_ferr; nd = n_dv;
        send_frame("7", 1'b1);
        idle(5);
        chk("seven_valid_count", n_valid - nv, 1);
        chk("seven_dv_count", n_dv - nd, 1);
        chk("seven_ferr_count", n_ferr - nf, 0);
        chk("seven_digit", int'(digit), 7);
        chk("seven_led", int'(LED), 8'h37);

        // Unlock window, back-to-back retrigger at expiry, lock at expiry
        send_frame("U", 1'b1);
        idle(110);
        chk("unlock_window", last_run, UNLOCK_CYCLES);
        send_frame("U", 1'b1);
        send_frame("U", 1'b1);
        idle(210);
        chk("unlock_retrigger", last_run, 2 * UNLOCK_CYCLES);
        send_frame("U", 1'b1);
        send_frame("L", 1'b1);
        idle(10);
        chk("unlock_lock", last_run, UNLOCK_CYCLES);
        chk("unlock_low_after_L", int'(unlock), 0);

        // Framing error followed by a held-low line
        nv = n_valid; nf = n_ferr;
        send_frame(8'h41, 1'b0);
        repeat (50) step(1'b0, 1'b0);
        chk("ferr_count", n_ferr - nf, 1);
        chk("ferr_no_valid", n_valid - nv, 0);
        chk("ferr_data_kept", int'(RxD_data), 8'h4C);
        idle(5);
        send_frame("2", 1'b1);
        idle(5);
        chk("after_ferr_data", int'(RxD_data), 8'h32);
        chk("after_ferr_digit", int'(digit), 2);

        // Short glitch on an idle line
        nv = n_valid; nf = n_ferr;
        repeat (3) step(1'b0, 1'b0);
        idle(20);
        chk("glitch_no_valid", n_valid - nv, 0);
        chk("glitch_no_ferr", n_ferr - nf, 0);
        send_frame("5", 1'b1);
        idle(5);
        chk("after_glitch_data", int'(RxD_data), 8'h35);
        chk("after_glitch_digit", int'(digit), 5);

        // Back-to-back frames with no idle between them
        k = vcyc_q.size();
        send_frame("1", 1'b1);
        chk("b2b_digit1", int'(digit), 1);
        send_frame("9", 1'b1);
        chk("b2b_digit9", int'(digit), 9);
        send_frame("U", 1'b1);
        idle(5);
        chk("b2b_count", vcyc_q.size() - k, 3);
        if (vcyc_q.size() - k == 3) begin
            chk("b2b_gap1", vcyc_q[k + 1] - vcyc_q[k], 10 * DIV);
            chk("b2b_gap2", vcyc_q[k + 2] - vcyc_q[k + 1], 10 * DIV);
        end
        chk("b2b_unlock", int'(unlock), 1);
        idle(110);

        // Reset in the middle of bit 4 of a 'U' frame
        nv = n_valid;
        rb = 8'h55;
        repeat (DIV) step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) repeat (DIV) step(rb[i], 1'b0);
        repeat (3) step(rb[4], 1'b0);
        repeat (3) step(1'b1, 1'b1);
        chk("midreset_outputs", int'({RxD_data, RxD_valid, frame_err, digit, digit_valid, unlock, LED}), 0);
        idle(DIV * 12);
        chk("midreset_no_valid", n_valid - nv, 0);
        chk("midreset_unlock", int'(unlock), 0);
        send_frame(8'h55, 1'b1);
        idle(5);
        chk("midreset_next_data", int'(RxD_data), 8'h55);
        chk("midreset_next_unlock", int'(unlock), 1);
        idle(110);

        // Randomized traffic against the reference model
        for (int n = 0; n < 20; n++) begin
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       rb = 8'h30 + 8'($urandom_range(0, 9));
                1:       rb = "U";
                2:       rb = "L";
                default: rb = 8'($urandom);
            endcase
            ok  = ($urandom_range(0, 7) != 0);
            gap = int'($urandom_range(0, 30));
            send_frame(rb, ok);
            if (!ok) begin
                repeat (int'($urandom_range(5, 40))) step(1'b0, 1'b0);
                gap = gap + 2;
            end
            idle(gap);
        end
        idle(UNLOCK_CYCLES + 20);
        chk("final_queue_empty", ev_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
